// File: rtl/rr_timeout_arbiter.sv
// Round-robin N-way arbiter with hold timeout and a dead cycle between grants.
// Ports: clk, reset (sync, active-high), req[N], grant[N], grant_id, busy, preempt.
module rr_timeout_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           preempt
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [IDW-1:0] r_ptr;
    logic [CW-1:0]  r_hold;
    logic [N-1:0]   r_grant;
    logic [IDW-1:0] r_id;
    logic           r_busy;
    logic           r_preempt;

    logic [IDW-1:0] w_ptr_nxt;
    logic [CW-1:0]  w_hold_nxt;
    logic [N-1:0]   w_grant_nxt;
    logic [IDW-1:0] w_id_nxt;
    logic           w_busy_nxt;
    logic           w_preempt_nxt;

    // Circular search: rotate req so that bit 0 corresponds to r_ptr.
    logic [2*N-2:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IDW-1:0] w_off;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_pick;
    logic           w_any;

    logic           w_own_req;
    logic           w_others;
    logic           w_sat;
    logic           w_release;
    logic           w_timeout;
    logic [IDW-1:0] w_ptr_adv;

    assign w_dbl = {req[N-2:0], req};
    assign w_rot = w_dbl[r_ptr +: N];
    assign w_any = |req;

    always_comb begin
        w_off = '0;
        // Descending scan so the lowest offset wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDW'(i);
            end
        end
    end

    assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_pick = (w_sum >= (IDW+1)'(N)) ? IDW'(w_sum - (IDW+1)'(N))
                                           : IDW'(w_sum);

    assign w_own_req = req[r_id];
    assign w_others  = |(req & ~r_grant);
    assign w_sat     = (r_hold == CW'(MAX_HOLD - 1));
    assign w_release = !w_own_req;
    // Timeout only applies while the owner still requests, so a
    // simultaneous drop is treated as a plain release.
    assign w_timeout = w_own_req && w_sat && w_others;
    assign w_ptr_adv = (r_id == IDW'(N - 1)) ? '0 : r_id + IDW'(1);

    // State register (outputs are registered alongside the state).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_grant   <= '0;
            r_id      <= '0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_grant   <= w_grant_nxt;
            r_id      <= w_id_nxt;
            r_busy    <= w_busy_nxt;
            r_preempt <= w_preempt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_release || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values; exits from GRANT always produce
    // an all-zero grant, giving the dead cycle.
    always_comb begin
        w_grant_nxt   = '0;
        w_id_nxt      = '0;
        w_busy_nxt    = 1'b0;
        w_preempt_nxt = 1'b0;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = {{(N-1){1'b0}}, 1'b1} << w_pick;
                    w_id_nxt    = w_pick;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = '0;
                end
            end
            S_GRANT: begin
                if (w_release || w_timeout) begin
                    w_ptr_nxt     = w_ptr_adv;
                    w_preempt_nxt = w_timeout;
                    w_hold_nxt    = '0;
                end else begin
                    w_grant_nxt = r_grant;
                    w_id_nxt    = r_id;
                    w_busy_nxt  = 1'b1;
                    if (!w_sat) begin
                        w_hold_nxt = r_hold + CW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign grant    = r_grant;
    assign grant_id = r_id;
    assign busy     = r_busy;
    assign preempt  = r_preempt;

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Self-checking bench for rr_timeout_arbiter (N=4, MAX_HOLD=4).
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_rr_timeout_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           preempt;

    int checks;
    int failures;

    // Behavioural model: owner index (-1 = none), cycles owned so far,
    // next search start, and pending preempt pulse.
    int   m_owner;
    int   m_cnt;
    int   m_ptr;
    logic m_pre;

    logic [N-1:0]   e_grant;
    logic [IDW-1:0] e_id;
    logic           e_busy;
    logic           e_pre;

    rr_timeout_arbiter #(
        .N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)
    ) dut (
        .clk(clk), .reset(reset), .req(req),
        .grant(grant), .grant_id(grant_id),
        .busy(busy), .preempt(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge(input logic rst, input logic [N-1:0] r);
        bit others;
        if (rst) begin
            m_owner = -1;
            m_cnt   = 0;
            m_ptr   = 0;
            m_pre   = 1'b0;
        end else if (m_owner < 0) begin
            m_pre = 1'b0;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (r[k] && m_owner < 0) begin
                    m_owner = k;
                    m_cnt   = 1;
                end
            end
        end else begin
            others = 0;
            for (int j = 0; j < N; j++)
                if (j != m_owner && r[j]) others = 1;
            if (!r[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_pre   = 1'b0;
            end else if (m_cnt >= MAX_HOLD && others) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_pre   = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        e_grant = (m_owner < 0) ? '0 : N'(1) << m_owner;
        e_id    = (m_owner < 0) ? '0 : IDW'(m_owner);
        e_busy  = (m_owner >= 0);
        e_pre   = m_pre;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(reset, req);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({grant, busy, preempt} !== 6'b0000_0_0) begin
                failures++;
                $display("FAIL reset_hold c=%0d got g=%b b=%b p=%b want 0000/0/0",
                         c, grant, busy, preempt);
            end
        end
        reset = 1'b0;
        req   = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({grant, grant_id, busy, preempt} !== 8'b0000_00_0_0) begin
                failures++;
                $display("FAIL reset_idle c=%0d got g=%b id=%0d b=%b p=%b want 0",
                         c, grant, grant_id, busy, preempt);
            end
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] eg;
        do_reset();
        req = 4'b1111;
        for (int r = 0; r < N; r++) begin
            eg = N'(1) << r;
            for (int c = 0; c < MAX_HOLD; c++) begin
                tick();
                checks++;
                if ({grant, grant_id, busy, preempt} !== {eg, IDW'(r), 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL rot_grant r=%0d c=%0d got g=%b id=%0d b=%b p=%b want g=%b",
                             r, c, grant, grant_id, busy, preempt, eg);
                end
            end
            tick();
            checks++;
            if ({grant, busy, preempt} !== {4'b0000, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL rot_dead r=%0d got g=%b b=%b p=%b want 0000/0/1",
                         r, grant, busy, preempt);
            end
        end
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL rot_wrap got=%b want=0001", grant);
        end
    endtask

    task automatic test_sole();
        int bad;
        do_reset();
        req = 4'b0100;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (grant !== 4'b0100 || grant_id !== 2'd2 || preempt !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sole_hold bad_cycles=%0d want 0 (last g=%b)", bad, grant);
        end
        req = 4'b0101;
        tick();
        checks++;
        if ({grant, busy, preempt} !== {4'b0000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL sole_preempt got g=%b b=%b p=%b want 0000/0/1",
                     grant, busy, preempt);
        end
        tick();
        checks++;
        if (grant !== 4'b0001 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL sole_next got g=%b id=%0d want 0001/0", grant, grant_id);
        end
    endtask

    task automatic test_release();
        do_reset();
        req = 4'b1010;
        tick();
        tick();
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL rel_own got=%b want=0010", grant);
        end
        req = 4'b1000;
        tick();
        checks++;
        if ({grant, busy, preempt} !== {4'b0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rel_dead got g=%b b=%b p=%b want 0000/0/0",
                     grant, busy, preempt);
        end
        tick();
        checks++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
            failures++;
            $display("FAIL rel_next got g=%b id=%0d want 1000/3", grant, grant_id);
        end
    endtask

    task automatic test_simul();
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < MAX_HOLD; c++) tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL sim_own got=%b want=0001", grant);
        end
        req = 4'b0010;
        tick();
        checks++;
        if ({grant, preempt} !== {4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL sim_dead got g=%b p=%b want 0000/0", grant, preempt);
        end
        tick();
        checks++;
        if (grant !== 4'b0010 || grant_id !== 2'd1) begin
            failures++;
            $display("FAIL sim_next got g=%b id=%0d want 0010/1", grant, grant_id);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({grant, busy} !== {4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL rmid_drop got g=%b b=%b want 0000/0", grant, busy);
        end
        reset = 1'b0;
        req   = 4'b1111;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL rmid_ptr got=%b want=0001", grant);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if ({grant, grant_id, busy, preempt} !== {e_grant, e_id, e_busy, e_pre}) begin
                failures++;
                $display("FAIL rand c=%0d req=%b got g=%b id=%0d b=%b p=%b want g=%b id=%0d b=%b p=%b",
                         c, req, grant, grant_id, busy, preempt,
                         e_grant, e_id, e_busy, e_pre);
            end
            checks++;
            if (!$onehot0(grant) || (preempt && busy)) begin
                failures++;
                $display("FAIL rand_inv c=%0d got g=%b b=%b p=%b want onehot0, !(p&b)",
                         c, grant, busy, preempt);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        req      = '0;
        m_owner  = -1;
        m_cnt    = 0;
        m_ptr    = 0;
        m_pre    = 1'b0;
        test_reset();
        test_rotation();
        test_sole();
        test_release();
        test_simul();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_timeout_arbiter.md
Name: rr_timeout_arbiter

Overview:
Round-robin arbiter that shares one resource among N requesters, generalising the team's fixed-priority 3-requester grant FSM. A grant is held while its requester keeps asserting request, and is revoked after MAX_HOLD cycles if another requester is waiting. One dead (no-grant) cycle separates consecutive grants for resource turnaround. It sits between the requesting masters and the shared resource's select/enable logic.

Parameters:
N, 4, number of requesters (2..16).
MAX_HOLD, 8, maximum consecutive grant cycles under contention (>=1).
IDW, 2, width of grant_id; must equal clog2(N).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
req  input  N  request vector; bit i = requester i.
grant  output  N  registered one-hot grant; all-zero when idle.
grant_id  output  IDW  index of the granted requester; 0 when idle.
busy  output  1  high while any grant bit is set.
preempt  output  1  one-cycle pulse in the first dead cycle after a timeout revocation.

Behaviour:
- Reset: the only reset is synchronous and active-high, sampled on the rising edge of clk. On that edge grant=0, grant_id=0, busy=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0. Reset overrides all other activity, including an active grant: grant drops at the reset edge.
- All outputs are registered.
- State IDLE (grant=0):
  - At an edge with req!=0, search circularly from index ptr upward (ptr, ptr+1, ..., N-1, 0, ...) and select the first set bit k.
  - Next cycle: grant=onehot(k), grant_id=k, busy=1, hold_cnt=0, state=GRANT.
  - Latency from req sampled to grant visible is 1 cycle.
  - With req=0, stay in IDLE.
- State GRANT (owner k):
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
  - Release: at an edge with req[k]=0, next cycle grant=0, state=IDLE, ptr=(k+1) mod N, preempt=0.
  - Timeout: at an edge with req[k]=1, hold_cnt==MAX_HOLD-1, and (req & ~onehot(k))!=0, next cycle grant=0, state=IDLE, ptr=(k+1) mod N, preempt=1.
  - Otherwise grant is held. A sole requester keeps the grant indefinitely with hold_cnt saturated. A competitor arriving later causes revocation at the first edge it is sampled.
- Dead cycle: every exit from GRANT passes through at least one IDLE cycle with grant=0. The earliest next grant is visible 2 cycles after the last grant cycle, i.e. one dead cycle.
- Under contention the owner holds the grant for exactly MAX_HOLD cycles. With MAX_HOLD=1, every grant lasts 1 cycle whenever others are waiting.
- Simultaneous release and timeout at the same edge count as a release: preempt=0.
- A requester that drops req during the dead cycle is not considered; arbitration uses only the req sampled at the IDLE edge.
- preempt is high for exactly one cycle and is never high while busy=1.
- grant is always zero or one-hot. grant_id is consistent with grant in every cycle.
- Requests arriving while another requester is granted are not queued beyond the level of req itself.

Test Plan:
1. Reset and idle. Hold reset=1 for 2 cycles with req=4'b1111, then deassert reset and set req=0. Required: grant=0000, busy=0, preempt=0 during reset and after.
2. Round-robin rotation. N=4, MAX_HOLD=4, req=1111 held constant after reset. Required: grant=0001 for 4 cycles, 1 dead cycle with preempt=1, then 0010 ×4, dead, 0100 ×4, dead, 1000 ×4, dead, then 0001 again.
3. Sole requester. req=0100 for 20 cycles. Required: grant=0100 from cycle 1 through cycle 20 with no preemption. Then assert req[0] at cycle 20. Required: grant drops at the next edge, preempt=1, and the following grant is 0001 (ptr=3 wraps to 0).
4. Voluntary release. req=0010, drop it after 2 grant cycles while req[3]=1. Required: 1 dead cycle with preempt=0, then grant=1000, grant_id=3.
5. Simultaneous release and timeout. Drop req[k] at exactly the edge where hold_cnt==MAX_HOLD-1 while others are requesting. Required: preempt=0, and the next grant goes to the next requester in circular order.
6. Reset mid-grant. Assert reset while grant=0010. Required: grant=0000 at that edge; after release, req=1111 yields 0001 first (ptr reset to 0).
